// File: rtl/clk_div_ctrl.sv
// Config controller for the integer clock divider: round-robin arbitration of two requesters.
// Changes are applied at a divided-clock low phase. Optional WAIT timeout: CLK_DIV_CTRL_TIMEOUT_EN.
module clk_div_ctrl #(
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned RST_RATIO  = 1,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned TIMEOUT_W  = 8
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_div_clk_mon,
    input  logic [1:0]       i_req,
    input  logic [DIV_W-1:0] i_ratio0,
    input  logic [DIV_W-1:0] i_ratio1,
    input  logic             i_en0,
    input  logic             i_en1,
    output logic [1:0]       o_ack,
    output logic             o_busy,
    output logic [DIV_W-1:0] o_div_ratio,
    output logic             o_clk_en,
    output logic             o_timeout
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT   = 3'd1;
    localparam logic [2:0] APPLY  = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] ACK    = 3'd4;

    localparam int unsigned        CNT_W       = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYC);
    localparam logic [DIV_W-1:0]   RST_VAL     = DIV_W'(RST_RATIO);

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic             en_q, en_d;
    logic [DIV_W-1:0] pend_ratio_q, pend_ratio_d;
    logic             pend_en_q, pend_en_d;
    logic             gnt_q, gnt_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mon_q;
    logic [1:0]       ack_q, ack_d;
    logic             busy_q, busy_d;

    logic             win;
    logic [DIV_W-1:0] win_ratio;
    logic             win_en;
    logic             div_active;
    logic             mon_fall;
    logic             to_expire;

    // rr_q names the requester preferred when both ask at once
    always_comb begin
        win = i_req[1];
        if (i_req == 2'b11) begin
            win = rr_q;
        end
    end

    assign win_ratio  = win ? i_ratio1 : i_ratio0;
    assign win_en     = win ? i_en1 : i_en0;
    assign div_active = en_q && (ratio_q >= DIV_W'(2));
    assign mon_fall   = mon_q && !i_div_clk_mon;

    always_comb begin
        state_d      = state_q;
        ratio_d      = ratio_q;
        en_d         = en_q;
        pend_ratio_d = pend_ratio_q;
        pend_en_d    = pend_en_q;
        gnt_d        = gnt_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    gnt_d        = win;
                    pend_ratio_d = win_ratio;
                    pend_en_d    = win_en;
                    if (win_ratio == ratio_q && win_en == en_q) begin
                        state_d = ACK;
                    end else if (div_active) begin
                        state_d = WAIT;
                    end else begin
                        state_d = APPLY;
                    end
                end
            end
            WAIT: begin
                if (mon_fall || to_expire) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                ratio_d = pend_ratio_q;
                en_d    = pend_en_q;
                cnt_d   = SETTLE_LOAD;
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                rr_d    = ~gnt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack_d  = (state_d == ACK) ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
    assign busy_d = (state_d != IDLE);

    // mon_q samples every cycle so WAIT entry compares against a fresh previous value
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            ratio_q      <= RST_VAL;
            en_q         <= 1'b0;
            pend_ratio_q <= RST_VAL;
            pend_en_q    <= 1'b0;
            gnt_q        <= 1'b0;
            rr_q         <= 1'b0;
            cnt_q        <= '0;
            mon_q        <= 1'b0;
            ack_q        <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ratio_q      <= ratio_d;
            en_q         <= en_d;
            pend_ratio_q <= pend_ratio_d;
            pend_en_q    <= pend_en_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            mon_q        <= i_div_clk_mon;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
        end
    end

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
    logic                 timeout_q, timeout_d;

    // Expires on the WAIT cycle whose increment reaches the all-ones count
    assign to_expire = (state_q == WAIT) && !mon_fall && (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if (state_q == IDLE && |i_req) begin
            to_cnt_d  = '0;
            timeout_d = 1'b0;
        end else if (state_q == WAIT) begin
            to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
            if (to_expire) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign to_expire = 1'b0;
    // Tied low; the replication only keeps TIMEOUT_W referenced in this build
    assign o_timeout = |{TIMEOUT_W{1'b0}};
`endif

    assign o_ack       = ack_q;
    assign o_busy      = busy_q;
    assign o_div_ratio = ratio_q;
    assign o_clk_en    = en_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: vector table for single requests plus hand-written
// sequences for arbitration, reset abort and WAIT timeout.
`timescale 1ns/1ps
module tb_clk_div_ctrl;

    localparam int unsigned DIV_W      = 8;
    localparam int unsigned SETTLE_CYC = 4;
    localparam int unsigned TIMEOUT_W  = 4;
    localparam int          S          = SETTLE_CYC;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mon;
    logic [1:0]       req;
    logic [DIV_W-1:0] ratio0, ratio1;
    logic             en0, en1;
    logic [1:0]       o_ack;
    logic             o_busy;
    logic [DIV_W-1:0] o_div_ratio;
    logic             o_clk_en;
    logic             o_timeout;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .DIV_W      (DIV_W),
        .RST_RATIO  (1),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT_W  (TIMEOUT_W)
    ) dut (
        .i_ref_clk     (clk),
        .i_rst_n       (rst_n),
        .i_div_clk_mon (mon),
        .i_req         (req),
        .i_ratio0      (ratio0),
        .i_ratio1      (ratio1),
        .i_en0         (en0),
        .i_en1         (en1),
        .o_ack         (o_ack),
        .o_busy        (o_busy),
        .o_div_ratio   (o_div_ratio),
        .o_clk_en      (o_clk_en),
        .o_timeout     (o_timeout)
    );

    typedef struct packed {
        logic [1:0]       ack;
        logic [DIV_W-1:0] ratio;
        logic             en;
    } exp_t;

    // path latencies are counted in edges after the grant edge k
    typedef struct {
        int         who;
        logic [7:0] ratio;
        logic       en;
        int         fall_dly;
        int         exp_chg;
        int         exp_ack;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[8];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] cur_ratio;
    logic       cur_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s sb_empty: got ack %b with no expected entry", tag, o_ack);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_ack"}, 32'(o_ack), 32'(e.ack));
        check({tag, "_ratio"}, 32'(o_div_ratio), 32'(e.ratio));
        check({tag, "_en"}, 32'(o_clk_en), 32'(e.en));
    endtask

    task automatic drive_req(input int who, input logic [7:0] r, input logic e);
        if (who == 0) begin
            ratio0 = r;
            en0    = e;
            req[0] = 1'b1;
            sb_q.push_back('{ack: 2'b01, ratio: r, en: e});
        end else begin
            ratio1 = r;
            en1    = e;
            req[1] = 1'b1;
            sb_q.push_back('{ack: 2'b10, ratio: r, en: e});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        mon   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cur_ratio = 8'd1;
        cur_en    = 1'b0;
    endtask

    // Called at a negedge; n counts negedges after the next posedge
    task automatic wait_ack(input string tag, input logic [1:0] drop, output int lat);
        lat = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (o_ack !== 2'b00) begin
                lat = n;
                sb_check(tag);
                req = req & ~drop;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s ack_timeout: no ack within 64 cycles", tag);
            req = req & ~drop;
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    chg_n;
        int    ack_n;
        string tag;
        tag   = $sformatf("vec%0d", idx);
        chg_n = -1;
        ack_n = -1;
        if (v.who == 0) begin
            ratio1 = 8'($urandom);
            en1    = 1'($urandom);
        end else begin
            ratio0 = 8'($urandom);
            en0    = 1'($urandom);
        end
        drive_req(v.who, v.ratio, v.en);
        mon = 1'b0;
        @(posedge clk);
        for (int n = 0; n < 64 && ack_n < 0; n++) begin
            @(negedge clk);
            if (n == 0) begin
                check({tag, "_busy_grant"}, 32'(o_busy), 32'd1);
                // post-grant input changes must be ignored
                if (v.who == 0) begin
                    ratio0 = ~v.ratio;
                    en0    = ~v.en;
                end else begin
                    ratio1 = ~v.ratio;
                    en1    = ~v.en;
                end
            end
            if (chg_n < 0 && (o_div_ratio !== cur_ratio || o_clk_en !== cur_en)) chg_n = n;
            if (v.fall_dly > 0) mon = (n < v.fall_dly);
            if (o_ack !== 2'b00) begin
                ack_n = n;
                sb_check(tag);
                check({tag, "_busy_ack"}, 32'(o_busy), 32'd1);
                req[v.who] = 1'b0;
            end
        end
        if (ack_n < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s ack_timeout: no ack within 64 cycles", tag);
            req[v.who] = 1'b0;
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
        check({tag, "_chg_cycle"}, 32'(chg_n), 32'(v.exp_chg));
        check({tag, "_ack_cycle"}, 32'(ack_n), 32'(v.exp_ack));
        mon = 1'b0;
        @(negedge clk);
        check({tag, "_ack_single"}, 32'(o_ack), 32'd0);
        check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        cur_ratio = v.ratio;
        cur_en    = v.en;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;

        ratio0 = '0;
        ratio1 = '0;
        en0    = 1'b0;
        en1    = 1'b0;
        // who, ratio, en, fall_dly, exp_chg, exp_ack
        vecs[0] = '{0, 8'd4,   1'b1, 0, 1,  1 + S};
        vecs[1] = '{1, 8'd6,   1'b1, 3, 5,  5 + S};
        vecs[2] = '{0, 8'd6,   1'b1, 0, -1, 0};
        vecs[3] = '{1, 8'd6,   1'b0, 1, 3,  3 + S};
        vecs[4] = '{0, 8'd0,   1'b1, 0, 1,  1 + S};
        vecs[5] = '{1, 8'd1,   1'b1, 0, 1,  1 + S};
        vecs[6] = '{0, 8'd255, 1'b1, 0, 1,  1 + S};
        vecs[7] = '{1, 8'd2,   1'b1, 5, 7,  7 + S};

        do_reset();
        check("rst_ratio", 32'(o_div_ratio), 32'd1);
        check("rst_en", 32'(o_clk_en), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);

        // Both high after reset: req0 first; then with both high again, req1 first
        ratio0 = 8'd3;
        en0    = 1'b0;
        ratio1 = 8'd5;
        en1    = 1'b0;
        req    = 2'b11;
        sb_q.push_back('{ack: 2'b01, ratio: 8'd3, en: 1'b0});
        wait_ack("rr_a", 2'b11, lat);
        check("rr_a_lat", 32'(lat), 32'(1 + S));
        @(negedge clk);
        check("rr_a_idle", 32'(o_busy), 32'd0);
        drive_req(1, 8'd9, 1'b0);
        drive_req(0, 8'd7, 1'b0);
        wait_ack("rr_b1", 2'b10, lat);
        check("rr_b1_lat", 32'(lat), 32'(1 + S));
        wait_ack("rr_b2", 2'b01, lat);
        check("rr_b2_lat", 32'(lat), 32'(2 + S));

        // Reset in SETTLE aborts the change; held request is served after release
        do_reset();
        drive_req(1, 8'd12, 1'b1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_applied", 32'(o_div_ratio), 32'd12);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_ratio", 32'(o_div_ratio), 32'd1);
        check("rstmid_en", 32'(o_clk_en), 32'd0);
        check("rstmid_busy", 32'(o_busy), 32'd0);
        check("rstmid_ack", 32'(o_ack), 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_ack !== 2'b00 || o_busy !== 1'b0) bad++;
        end
        check("rstmid_hold", 32'(bad), 32'd0);
        rst_n = 1'b1;
        wait_ack("rstmid_redo", 2'b10, lat);
        check("rstmid_redo_lat", 32'(lat), 32'(1 + S));
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Divider active at ratio 2; mon held high so no falling edge appears
        mon = 1'b1;
        @(negedge clk);
        drive_req(0, 8'd3, 1'b1);
        @(posedge clk);
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        lat = -1;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            if (n == 14) begin
                check("to_pre_flag", 32'(o_timeout), 32'd0);
                check("to_pre_ratio", 32'(o_div_ratio), 32'd2);
            end
            if (n == 15) begin
                check("to_flag", 32'(o_timeout), 32'd1);
                check("to_apply_ratio_old", 32'(o_div_ratio), 32'd2);
            end
            if (n == 16) check("to_ratio_new", 32'(o_div_ratio), 32'd3);
            if (o_ack !== 2'b00) begin
                lat = n;
                sb_check("to_ack");
                req[0] = 1'b0;
            end
        end
        check("to_ack_cycle", 32'(lat), 32'(16 + S));
        mon = 1'b0;
        repeat (3) @(negedge clk);
        check("to_sticky", 32'(o_timeout), 32'd1);
        drive_req(1, 8'd3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("to_clear_on_grant", 32'(o_timeout), 32'd0);
        sb_check("to_same");
        req[1] = 1'b0;
`else
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (o_ack !== 2'b00 || o_timeout !== 1'b0 || o_busy !== 1'b1 ||
                o_div_ratio !== 8'd2) bad++;
        end
        check("wait_hold", 32'(bad), 32'd0);
        mon = 1'b0;
        wait_ack("wait_release", 2'b01, lat);
        check("wait_release_lat", 32'(lat), 32'(1 + S));
        check("wait_timeout_low", 32'(o_timeout), 32'd0);
`endif
        @(negedge clk);
        check("final_idle", 32'(o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
